// File: rtl/ras_if.sv
// Return-address-stack port bundle between fetch (master) and the predictor (slave).
interface ras_if #(
  parameter int unsigned RAS_DEPTH        = 8,
  parameter int unsigned RAS_TARGET_WIDTH = 12
);
  localparam int unsigned LOG_RAS_DEPTH = $clog2(RAS_DEPTH);

  logic                        push_valid;
  logic [RAS_TARGET_WIDTH-1:0] push_target;
  logic                        pop_valid;
  logic                        restore_valid;
  logic [LOG_RAS_DEPTH-1:0]    restore_index;
  logic [LOG_RAS_DEPTH:0]      restore_count;
  logic [RAS_TARGET_WIDTH-1:0] restore_top_target;
  logic [RAS_TARGET_WIDTH-1:0] pop_target;
  logic [LOG_RAS_DEPTH-1:0]    ras_index;
  logic [LOG_RAS_DEPTH:0]      ras_count;
  logic                        underflow;

  modport master (
    output push_valid, push_target, pop_valid,
    output restore_valid, restore_index, restore_count, restore_top_target,
    input  pop_target, ras_index, ras_count, underflow
  );

  modport slave (
    input  push_valid, push_target, pop_valid,
    input  restore_valid, restore_index, restore_count, restore_top_target,
    output pop_target, ras_index, ras_count, underflow
  );
endinterface

// File: rtl/ras_predictor.sv
// Circular return-address stack with checkpoint restore for branch prediction.
// Optional RAS_TOP_REPAIR_EN: restore also rewrites the checkpointed top entry.
module ras_predictor #(
  parameter int unsigned RAS_DEPTH        = 8,
  parameter int unsigned RAS_TARGET_WIDTH = 12
) (
  input  logic clk,
  input  logic rst,
  ras_if.slave ras
);
  localparam int unsigned LOG_RAS_DEPTH = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W         = LOG_RAS_DEPTH + 1;

  logic [RAS_TARGET_WIDTH-1:0] entry_q [RAS_DEPTH];
  logic [LOG_RAS_DEPTH-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        underflow_q, underflow_d;
  logic                        wr_en;
  logic [LOG_RAS_DEPTH-1:0]    wr_idx;
  logic [RAS_TARGET_WIDTH-1:0] wr_data;

  // Next-state: restore outranks push/pop; push+pop replaces the top in place.
  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = ptr_q;
    wr_data     = ras.push_target;
    if (ras.restore_valid) begin
      ptr_d   = ras.restore_index;
      count_d = (ras.restore_count > CNT_W'(RAS_DEPTH)) ? CNT_W'(RAS_DEPTH)
                                                        : ras.restore_count;
`ifdef RAS_TOP_REPAIR_EN
      wr_en   = 1'b1;
      wr_idx  = ras.restore_index;
      wr_data = ras.restore_top_target;
`endif
    end else if (ras.push_valid && ras.pop_valid) begin
      wr_en       = 1'b1;
      underflow_d = (count_q == '0);
    end else if (ras.push_valid) begin
      ptr_d   = ptr_q + LOG_RAS_DEPTH'(1);
      wr_en   = 1'b1;
      wr_idx  = ptr_q + LOG_RAS_DEPTH'(1);
      count_d = (count_q == CNT_W'(RAS_DEPTH)) ? count_q : count_q + CNT_W'(1);
    end else if (ras.pop_valid) begin
      ptr_d       = ptr_q - LOG_RAS_DEPTH'(1);
      count_d     = (count_q != '0) ? count_q - CNT_W'(1) : '0;
      underflow_d = (count_q == '0);
    end
  end

`ifndef RAS_TOP_REPAIR_EN
  // Checkpointed top value only matters when top repair is built in.
  logic unused_restore_top;
  assign unused_restore_top = ^ras.restore_top_target;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) entry_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      if (wr_en) entry_q[wr_idx] <= wr_data;
    end
  end

  assign ras.pop_target = entry_q[ptr_q];
  assign ras.ras_index  = ptr_q;
  assign ras.ras_count  = count_q;
  assign ras.underflow  = underflow_q;
endmodule
